// File: rtl/ex_iter_if.sv
// Execute-stage handshake bundle between the ID/EX register (master) and ex_iter_unit (slave).
interface ex_iter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid_i;
  logic [3:0]        op_i;
  logic [DATA_W-1:0] reg_1;
  logic [DATA_W-1:0] reg_2;
  logic [DATA_W-1:0] link_addr_i;
  logic [ADDR_W-1:0] waddr;
  logic              we;
  logic              flush_i;
  logic              ready_o;
  logic              busy_o;
  logic              valid_o;
  logic [DATA_W-1:0] wdata_o;
  logic [ADDR_W-1:0] waddr_o;
  logic              we_o;

  modport master (
    output valid_i, op_i, reg_1, reg_2, link_addr_i, waddr, we, flush_i,
    input  ready_o, busy_o, valid_o, wdata_o, waddr_o, we_o
  );

  modport slave (
    input  valid_i, op_i, reg_1, reg_2, link_addr_i, waddr, we, flush_i,
    output ready_o, busy_o, valid_o, wdata_o, waddr_o, we_o
  );
endinterface

// File: rtl/ex_iter_unit.sv
// Execute stage: registered single-cycle ALU plus iterative shift-add multiplier / restoring divider.
// Define EX_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational product.
module ex_iter_unit #(
  parameter int  DATA_W  = 32,
  parameter int  ADDR_W  = 5,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input logic      clk,
  input logic      rst,
  ex_iter_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [3:0] OP_NOP = 4'd0,  OP_OR  = 4'd1,  OP_AND   = 4'd2,  OP_XOR  = 4'd3,
                         OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_SLL   = 4'd6,  OP_SRL  = 4'd7,
                         OP_SRA = 4'd8,  OP_LUI = 4'd9,  OP_LINK  = 4'd10, OP_MUL  = 4'd11,
                         OP_MULH = 4'd12, OP_MULHU = 4'd13, OP_DIV = 4'd14, OP_REM = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_next;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic signed [DATA_W-1:0] a_s, b_s;
  logic [DATA_W-1:0]        a_mag, b_mag, alu_res, iter_res, quo_fix, rem_fix;
  logic [SHAMT_W-1:0]       shamt;
  logic [DATA_W+31:0]       lui_wide;
  logic                     is_mul, is_div, signed_op, sa, sb;
  logic                     accept, start_mul, start_div, start_single;

  // iteration state, held for the whole multi-cycle run
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic                we_q, neg_q, rem_neg_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc, mcand, prod_fix;
  logic [DATA_W-1:0]   shr, rem, divisor;
  logic [DATA_W:0]     div_shift, div_trial;
  logic                div_ge, last_iter;

  logic              vld_p1, we_p1, busy_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [ADDR_W-1:0] waddr_p1;

  assign a_s       = bus.reg_1;
  assign b_s       = bus.reg_2;
  assign is_mul    = (bus.op_i == OP_MUL) || (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHU);
  assign is_div    = (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
  assign signed_op = (bus.op_i != OP_MULHU);
  assign sa        = signed_op && a_s[DATA_W-1];
  assign sb        = signed_op && b_s[DATA_W-1];
  assign a_mag     = neg_w(bus.reg_1, sa);
  assign b_mag     = neg_w(bus.reg_2, sb);
  assign shamt     = bus.reg_2[SHAMT_W-1:0];
  assign lui_wide  = {32'h0, bus.reg_1};

  // busy_o is low exactly when the FSM sits in IDLE, so it doubles as the accept gate
  assign accept = bus.valid_i && !busy_p1 && !bus.flush_i;
`ifdef EX_FAST_MUL_EN
  assign start_mul = 1'b0;
`else
  assign start_mul = accept && is_mul;
`endif
  assign start_div    = accept && is_div;
  assign start_single = accept && !start_mul && !start_div;

`ifdef EX_FAST_MUL_EN
  logic signed [2*DATA_W-1:0] prod_ss;
  logic [2*DATA_W-1:0]        prod_uu;
  assign prod_ss = $signed({{DATA_W{a_s[DATA_W-1]}}, a_s}) * $signed({{DATA_W{b_s[DATA_W-1]}}, b_s});
  assign prod_uu = {{DATA_W{1'b0}}, bus.reg_1} * {{DATA_W{1'b0}}, bus.reg_2};
`endif

  always_comb begin
    alu_res = '0;
    case (bus.op_i)
      OP_OR:   alu_res = bus.reg_1 | bus.reg_2;
      OP_AND:  alu_res = bus.reg_1 & bus.reg_2;
      OP_XOR:  alu_res = bus.reg_1 ^ bus.reg_2;
      OP_ADD:  alu_res = bus.reg_1 + bus.reg_2;
      OP_SUB:  alu_res = bus.reg_1 - bus.reg_2;
      OP_SLL:  alu_res = bus.reg_1 << shamt;
      OP_SRL:  alu_res = bus.reg_1 >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_LUI:  alu_res = DATA_W'({lui_wide[15:0], 16'h0000});
      OP_LINK: alu_res = bus.link_addr_i;
`ifdef EX_FAST_MUL_EN
      OP_MUL:   alu_res = prod_uu[DATA_W-1:0];
      OP_MULH:  alu_res = prod_ss[2*DATA_W-1:DATA_W];
      OP_MULHU: alu_res = prod_uu[2*DATA_W-1:DATA_W];
`endif
      default: alu_res = '0;
    endcase
  end

  // restoring divide step: rem < divisor keeps the trial's top bit a pure borrow flag
  assign div_shift = {rem, shr[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, divisor};
  assign div_ge    = !div_trial[DATA_W];
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start_mul) state_next = S_MUL;
                    else if (start_div) state_next = S_DIV;
      S_MUL, S_DIV: if (last_iter) state_next = S_DONE;
      S_DONE:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
    if (bus.flush_i) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (start_mul || start_div) begin
      op_q      <= bus.op_i;
      waddr_q   <= bus.waddr;
      we_q      <= bus.we;
      cnt       <= '0;
      acc       <= '0;
      rem       <= '0;
      mcand     <= {{DATA_W{1'b0}}, a_mag};
      shr       <= start_div ? a_mag : b_mag;
      divisor   <= b_mag;
      // a zero divisor must yield all ones, so its quotient is never negated
      neg_q     <= (sa ^ sb) && !(start_div && (bus.reg_2 == '0));
      rem_neg_q <= sa;
    end else if (state == S_MUL) begin
      if (shr[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      shr   <= shr >> 1;
      cnt   <= cnt + CNT_W'(1);
    end else if (state == S_DIV) begin
      rem <= div_ge ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
      shr <= {shr[DATA_W-2:0], div_ge};
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign prod_fix = neg_2w(acc, neg_q);
  assign quo_fix  = neg_w(shr, neg_q);
  assign rem_fix  = neg_w(rem, rem_neg_q);

  always_comb begin
    iter_res = rem_fix;
    case (op_q)
      OP_MUL:            iter_res = prod_fix[DATA_W-1:0];
      OP_MULH, OP_MULHU: iter_res = prod_fix[2*DATA_W-1:DATA_W];
      OP_DIV:            iter_res = quo_fix;
      default:           iter_res = rem_fix;
    endcase
  end

  // p1: registered result stage toward MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      wdata_p1 <= '0;
      waddr_p1 <= '0;
      we_p1    <= 1'b0;
      busy_p1  <= 1'b0;
    end else begin
      busy_p1 <= (state_next != S_IDLE);
      if (bus.flush_i) begin
        vld_p1 <= 1'b0;
        we_p1  <= 1'b0;
      end else if (start_single) begin
        vld_p1   <= 1'b1;
        wdata_p1 <= alu_res;
        waddr_p1 <= bus.waddr;
        we_p1    <= bus.we && (bus.op_i != OP_NOP);
      end else if (state == S_DONE) begin
        vld_p1   <= 1'b1;
        wdata_p1 <= iter_res;
        waddr_p1 <= waddr_q;
        we_p1    <= we_q;
      end else begin
        vld_p1 <= 1'b0;
        we_p1  <= 1'b0;
      end
    end
  end

  assign bus.valid_o = vld_p1;
  assign bus.wdata_o = wdata_p1;
  assign bus.waddr_o = waddr_p1;
  assign bus.we_o    = we_p1;
  assign bus.busy_o  = busy_p1;
  assign bus.ready_o = !busy_p1;
endmodule

// File: tb/tb_ex_iter_unit.sv
// Directed bench for ex_iter_unit at DATA_W=32: ALU ops, mul/div results and latency, flush, reset.
`timescale 1ns/1ps
module tb_ex_iter_unit;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef EX_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = DATA_W + 1;
`endif
  localparam int DIV_LAT = DATA_W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_iter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ex_iter_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op at a negedge, scramble inputs after the accept edge, wait for valid_o.
  // lat counts samples after the accept edge that precede valid_o.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   n;
    int   busy_n;
    logic got_v;
    logic [ADDR_W-1:0] wa;
    wa = ADDR_W'($urandom_range(1, 31));
    check({tag, "_ready"}, bus.ready_o, 1'b1);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.reg_1   = a;
    bus.reg_2   = b;
    bus.waddr   = wa;
    bus.we      = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.op_i    = 4'd0;
    bus.reg_1   = $urandom();
    bus.reg_2   = $urandom();
    bus.waddr   = '0;
    bus.we      = 1'b0;
    n = 0;
    busy_n = 0;
    got_v = 1'b0;
    while (!got_v && n < 100) begin
      @(negedge clk);
      if (bus.valid_o) got_v = 1'b1;
      else begin
        n++;
        if (bus.busy_o) busy_n++;
      end
    end
    check({tag, "_valid"}, got_v, 1'b1);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat);
    check({tag, "_busy_at_valid"}, bus.busy_o, 1'b0);
    check({tag, "_data"}, bus.wdata_o, exp);
    check({tag, "_waddr"}, bus.waddr_o, wa);
    check({tag, "_we"}, bus.we_o, (op != 4'd0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.op_i = 4'd0;
    bus.reg_1 = '0;
    bus.reg_2 = '0;
    bus.link_addr_i = 32'h0040_0010;
    bus.waddr = '0;
    bus.we = 1'b0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_wdata", bus.wdata_o, 32'h0);
    check("rst_waddr", bus.waddr_o, 5'h0);
    check("rst_we", bus.we_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_ready", bus.ready_o, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 4'd4, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
    run_op("sub_neg",  4'd5, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0);
    run_op("or",       4'd1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0);
    run_op("and",      4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0);
    run_op("xor",      4'd3, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0);
    run_op("sll31",    4'd6, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 0);
    run_op("srl",      4'd7, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 0);
    run_op("sra",      4'd8, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0);
    run_op("sra_mask", 4'd8, 32'h8000_0000, 32'h0000_0023, 32'hF000_0000, 0);
    run_op("lui",      4'd9, 32'h1234_ABCD, 32'h0, 32'hABCD_0000, 0);
    run_op("link",     4'd10, 32'h0, 32'h0, 32'h0040_0010, 0);
    run_op("nop",      4'd0, 32'h1234_5678, 32'h1, 32'h0, 0);

    run_op("mulh_m3x5", 4'd12, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, MUL_LAT);
    @(negedge clk);
    check("mulh_pulse", bus.valid_o, 1'b0);
    run_op("mul_m3x5",   4'd11, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, MUL_LAT);
    run_op("mulhu_max",  4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh_negneg",4'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, MUL_LAT);
    run_op("mul_negneg", 4'd11, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0006, MUL_LAT);
    run_op("mulh_min2",  4'd12, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulh_2p32",  4'd12, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT);

    run_op("div_m7_2",   4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2",   4'd15, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_7_m2",   4'd14, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_7_m2",   4'd15, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
    run_op("div_100_7",  4'd14, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_op("rem_100_7",  4'd15, 32'd100, 32'd7, 32'd2, DIV_LAT);
    run_op("div_ovf",    4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
    run_op("rem_ovf",    4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT);
    run_op("div_5_0",    4'd14, 32'd5, 32'd0, 32'hFFFF_FFFF, DIV_LAT);
    run_op("rem_5_0",    4'd15, 32'd5, 32'd0, 32'd5, DIV_LAT);
    run_op("div_m5_0",   4'd14, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, DIV_LAT);
    run_op("rem_m5_0",   4'd15, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, DIV_LAT);

    // flush an in-flight divide at cycle 10; a same-cycle op is discarded
    @(negedge clk);
    bus.valid_i = 1'b1; bus.op_i = 4'd14; bus.reg_1 = 32'd100; bus.reg_2 = 32'd7;
    bus.waddr = 5'd3; bus.we = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", bus.busy_o, 1'b1);
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1; bus.op_i = 4'd4; bus.reg_1 = 32'd1; bus.reg_2 = 32'd2;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid", bus.valid_o, 1'b0);
    check("flush_ready", bus.ready_o, 1'b1);
    check("flush_busy", bus.busy_o, 1'b0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_o) vcount++;
    end
    check("flush_no_result", vcount, 0);

    // flush and valid_i together in IDLE: flush wins
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1; bus.op_i = 4'd4; bus.reg_1 = 32'd1; bus.reg_2 = 32'd2;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("flush_wins_valid", bus.valid_o, 1'b0);
    check("flush_wins_busy", bus.busy_o, 1'b0);

    run_op("sll_masked", 4'd6, 32'h0000_0001, 32'd36, 32'h0000_0010, 0);

    // reset in the middle of a multiply
    bus.valid_i = 1'b1; bus.op_i = 4'd11; bus.reg_1 = 32'd3; bus.reg_2 = 32'd5;
    bus.waddr = 5'd9; bus.we = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid", bus.valid_o, 1'b0);
    check("rstmid_wdata", bus.wdata_o, 32'h0);
    check("rstmid_waddr", bus.waddr_o, 5'h0);
    check("rstmid_we", bus.we_o, 1'b0);
    check("rstmid_busy", bus.busy_o, 1'b0);
    check("rstmid_ready", bus.ready_o, 1'b1);
    run_op("or_after_rst", 4'd1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_o) vcount++;
    end
    check("rstmid_no_stale", vcount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
